// File: rtl/apple_cell_checker.sv
// apple_cell_checker
// Decides whether the apple generator may place an apple on a candidate cell.
// A cell is rejected when it lies outside the play grid or when any snake segment
// already occupies it. The snake body RAM is read one segment per cycle, and the
// scan stops early on the first hit.
// Optional build macro: CHECKER_STATS_EN adds reject_count_o, a saturating
// 8-bit count of rejected cells.

module apple_cell_checker #(
    parameter int MAX_LEN = 64,
    parameter int IDX_W   = 6,
    parameter int GRID_W  = 19,
    parameter int GRID_H  = 13
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             check_req_i,
    input  logic [4:0]       cand_x_i,
    input  logic [4:0]       cand_y_i,
    input  logic [IDX_W:0]   snake_len_i,
    output logic [IDX_W-1:0] seg_rd_addr_o,
    input  logic [4:0]       seg_rd_x_i,
    input  logic [4:0]       seg_rd_y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_apple_o
`ifdef CHECKER_STATS_EN
    ,
    output logic [7:0]       reject_count_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        RESULT
    } state_e;

    localparam logic [4:0]     GRID_X_LIM = 5'(GRID_W);
    localparam logic [4:0]     GRID_Y_LIM = 5'(GRID_H);
    localparam logic [IDX_W:0] MAX_LEN_C  = (IDX_W+1)'(MAX_LEN);
    localparam logic [IDX_W:0] LEN_ONE    = (IDX_W+1)'(1);

    state_e           state_q, state_d;
    logic [4:0]       candX_q, candX_d;
    logic [4:0]       candY_q, candY_d;
    logic [IDX_W:0]   len_q, len_d;
    logic [IDX_W-1:0] segAddr_q, segAddr_d;
    logic             pipeValid_q, pipeValid_d;
    logic             validApple_q, validApple_d;

    logic             outOfGrid;
    logic             segHit;
    logic             lastAddr;

    // Decode helpers: grid bounds of the incoming candidate, a hit on the segment
    // returned by the RAM this cycle, and whether the address issued now is the last one
    always_comb begin
        outOfGrid = (cand_x_i >= GRID_X_LIM) || (cand_y_i >= GRID_Y_LIM);
        segHit    = pipeValid_q && (seg_rd_x_i == candX_q) && (seg_rd_y_i == candY_q);
        lastAddr  = ({1'b0, segAddr_q} == (len_q - LEN_ONE));
    end

    // State and datapath registers; reset clears everything so an aborted scan leaves no trace
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            candX_q      <= '0;
            candY_q      <= '0;
            len_q        <= '0;
            segAddr_q    <= '0;
            pipeValid_q  <= 1'b0;
            validApple_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            candX_q      <= candX_d;
            candY_q      <= candY_d;
            len_q        <= len_d;
            segAddr_q    <= segAddr_d;
            pipeValid_q  <= pipeValid_d;
            validApple_q <= validApple_d;
        end
    end

    // Next-state logic; the verdict is written on the way into RESULT so it is
    // already visible in the cycle where done_o pulses
    always_comb begin
        state_d      = state_q;
        candX_d      = candX_q;
        candY_d      = candY_q;
        len_d        = len_q;
        segAddr_d    = segAddr_q;
        pipeValid_d  = 1'b0;
        validApple_d = validApple_q;

        case (state_q)
            IDLE: begin
                if (check_req_i) begin
                    candX_d = cand_x_i;
                    candY_d = cand_y_i;
                    len_d   = (snake_len_i > MAX_LEN_C) ? MAX_LEN_C : snake_len_i;
                    if (outOfGrid) begin
                        validApple_d = 1'b0;
                        state_d      = RESULT;
                    end else if (len_d == '0) begin
                        validApple_d = 1'b1;
                        state_d      = RESULT;
                    end else begin
                        segAddr_d = '0;
                        state_d   = SCAN;
                    end
                end
            end
            SCAN: begin
                if (segHit) begin
                    validApple_d = 1'b0;
                    state_d      = RESULT;
                end else begin
                    pipeValid_d = 1'b1;
                    if (lastAddr) begin
                        state_d = DRAIN;
                    end else begin
                        segAddr_d = segAddr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                validApple_d = !segHit;
                state_d      = RESULT;
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        busy_o        = (state_q != IDLE);
        done_o        = (state_q == RESULT);
        seg_rd_addr_o = segAddr_q;
        valid_apple_o = validApple_q;
    end

`ifdef CHECKER_STATS_EN
    logic [7:0] rejectCount_q;

    // Saturating count of rejected cells, bumped once per result pulse
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rejectCount_q <= '0;
        end else if ((state_q == RESULT) && !validApple_q && (rejectCount_q != 8'hFF)) begin
            rejectCount_q <= rejectCount_q + 8'd1;
        end
    end

    assign reject_count_o = rejectCount_q;
`endif

endmodule
